// File: rtl/p2p_sum_stim.sv
// Far-end partner for a group-sum block: produces LFSR samples on din, predicts
// each group sum, absorbs dout under a rotating backpressure pattern, and scores it.
module p2p_sum_stim #(
  parameter int GROUP     = 8,
  parameter int DIN_W     = 8,
  parameter int DOUT_W    = 11,
  parameter int EXP_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_groups,
  input  logic [7:0]        seed,
  input  logic [7:0]        busy_pat,
  input  logic              din_busy,
  output logic              din_vld,
  output logic [DIN_W-1:0]  din_data,
  output logic              dout_busy,
  input  logic              dout_vld,
  input  logic [DOUT_W-1:0] dout_data,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic              timeout,
  output logic [1:0]        fsm_state
);

  // Handshake: a word moves on a rising edge where vld=1 and busy=0; a producer
  // holds vld and data stable until that edge and never withdraws vld early.

  localparam int CW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int AW = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [15:0]       num_groups_r;
  logic [7:0]        lfsr;
  logic [7:0]        busy_rot;
  logic [DOUT_W-1:0] acc;
  logic [CW-1:0]     sample_cnt;
  logic [15:0]       groups_sent;
  logic [15:0]       outs_rcvd;
  logic [TW-1:0]     idle_cnt;
  logic [DOUT_W-1:0] fifo_mem [EXP_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fifo_cnt;

  logic              active;
  logic              din_xfer;
  logic              dout_xfer;
  logic              fifo_empty;
  logic              last_sample;
  logic              push;
  logic              pop;
  logic              err_inc;
  logic              more_to_send;
  logic              vld_next;
  logic [7:0]        lfsr_nx;
  logic [7:0]        seed_eff;
  logic [DOUT_W-1:0] sample_sum;
  logic [AW:0]       cnt_next;
  logic [CW-1:0]     sample_cnt_next;
  logic [15:0]       groups_next;
  logic [15:0]       err_next;

  assign fsm_state = state;

  always_comb begin
    active          = (state == S_SEND) || (state == S_DRAIN);
    din_xfer        = din_vld && !din_busy;
    dout_xfer       = dout_vld && !dout_busy && active;
    fifo_empty      = (fifo_cnt == '0);
    last_sample     = (sample_cnt == CW'(GROUP - 1));
    push            = din_xfer && last_sample;
    pop             = dout_xfer && !fifo_empty;
    err_inc         = dout_xfer && (fifo_empty || (fifo_mem[rd_ptr] != dout_data));
    err_next        = (err_inc && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    // Galois form of x^8+x^6+x^5+x^4+1, shifting toward bit 0.
    lfsr_nx         = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    seed_eff        = (seed == 8'h00) ? 8'h01 : seed;
    sample_sum      = acc + DOUT_W'(din_data);
    cnt_next        = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    sample_cnt_next = sample_cnt;
    if (din_xfer) sample_cnt_next = last_sample ? '0 : sample_cnt + CW'(1);
    groups_next     = groups_sent + 16'(push);
    more_to_send    = (groups_next != num_groups_r);
    // A new group only starts when its sum is guaranteed a FIFO slot.
    vld_next        = more_to_send &&
                      ((sample_cnt_next != '0) || (cnt_next != (AW+1)'(EXP_DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      num_groups_r <= '0;
      lfsr         <= 8'h01;
      busy_rot     <= '0;
      acc          <= '0;
      sample_cnt   <= '0;
      groups_sent  <= '0;
      outs_rcvd    <= '0;
      idle_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      din_vld      <= 1'b0;
      din_data     <= '0;
      dout_busy    <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      timeout      <= 1'b0;
    end else begin
      if (active) begin
        busy_rot  <= {busy_rot[0], busy_rot[7:1]};
        dout_busy <= busy_rot[1];
        fifo_cnt  <= cnt_next;
        err_cnt   <= err_next;
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (dout_xfer) outs_rcvd <= outs_rcvd + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            num_groups_r <= num_groups;
            lfsr         <= seed_eff;
            din_data     <= DIN_W'(seed_eff);
            busy_rot     <= busy_pat;
            acc          <= '0;
            sample_cnt   <= '0;
            groups_sent  <= '0;
            outs_rcvd    <= '0;
            idle_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            err_cnt      <= '0;
            timeout      <= 1'b0;
            if (num_groups == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state     <= S_SEND;
              din_vld   <= 1'b1;
              dout_busy <= busy_pat[0];
            end
          end
        end

        S_SEND: begin
          if (din_xfer) begin
            lfsr       <= lfsr_nx;
            din_data   <= DIN_W'(lfsr_nx);
            acc        <= last_sample ? '0 : sample_sum;
            sample_cnt <= sample_cnt_next;
          end
          if (push) begin
            fifo_mem[wr_ptr] <= sample_sum;
            wr_ptr           <= wr_ptr + AW'(1);
            groups_sent      <= groups_next;
          end
          if (!din_vld || din_xfer) din_vld <= vld_next;
          if (push && !more_to_send) begin
            state    <= S_DRAIN;
            idle_cnt <= '0;
          end
        end

        S_DRAIN: begin
          if (fifo_empty && (outs_rcvd == num_groups_r)) begin
            state     <= S_DONE;
            done      <= 1'b1;
            pass      <= (err_next == 16'd0) && !timeout;
            dout_busy <= 1'b1;
          end else if (dout_xfer) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state     <= S_DONE;
            timeout   <= 1'b1;
            done      <= 1'b1;
            pass      <= 1'b0;
            dout_busy <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        S_DONE: begin
          if (start) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            timeout     <= 1'b0;
            sample_cnt  <= '0;
            groups_sent <= '0;
            outs_rcvd   <= '0;
            idle_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            acc         <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2p_sum_stim.sv
// Bench for p2p_sum_stim: a behavioural group-sum dut on the far side of the
// p2p ports, a din scoreboard fed at run start, and end-of-run status checks.
module tb_p2p_sum_stim;

  localparam int GROUP = 8;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_groups = '0;
  logic [7:0]  seed = '0;
  logic [7:0]  busy_pat = '0;
  logic        din_busy = 1'b0;
  logic        din_vld;
  logic [7:0]  din_data;
  logic        dout_busy;
  logic        dout_vld = 1'b0;
  logic [10:0] dout_data = '0;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic        timeout;
  logic [1:0]  fsm_state;

  p2p_sum_stim dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .seed(seed),
    .busy_pat(busy_pat), .din_busy(din_busy), .din_vld(din_vld), .din_data(din_data),
    .dout_busy(dout_busy), .dout_vld(dout_vld), .dout_data(dout_data), .done(done),
    .pass(pass), .err_cnt(err_cnt), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // ---------------- model dut (far side) ----------------
  int          m_acc, m_cnt, m_grp, busy_left, corrupt_grp, m_first_sum;
  bit          withhold;
  logic [10:0] res_q[$];

  initial begin : model_dut
    logic dx, ox;
    forever begin
      @(negedge clk);
      dx = din_vld && !din_busy && rst;
      ox = dout_vld && !dout_busy && rst;
      if (dx) begin
        m_acc += int'(din_data);
        m_cnt++;
        if (m_cnt == GROUP) begin
          if (m_grp == 0) m_first_sum = m_acc;
          res_q.push_back(11'(m_acc + ((m_grp == corrupt_grp) ? 1 : 0)));
          m_grp++;
          m_acc = 0;
          m_cnt = 0;
        end
      end
      if (ox && res_q.size() > 0) void'(res_q.pop_front());
      @(posedge clk);
      #1;
      din_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (!withhold && res_q.size() > 0) begin
        dout_vld  = 1'b1;
        dout_data = res_q[0];
      end else begin
        dout_vld = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int   cyc = 0;
  int   vld_seen, din_xfers, first_din, last_din, dout_xfers, last_dout, back_to_back;
  bit   pend_prev;
  logic [7:0] pend_data;

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (din_vld) vld_seen++;
      if (pend_prev) begin
        check("din_vld_hold", din_vld, 1'b1);
        check("din_data_hold", din_data, pend_data);
      end
      pend_prev = din_vld && din_busy && rst;
      pend_data = din_data;
      if (din_vld && !din_busy && rst) begin
        if (exp_q.size() == 0) begin
          check("din_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("din_data", din_data, e);
        end
        if (din_xfers == 0) first_din = cyc;
        last_din = cyc;
        din_xfers++;
      end
      if (dout_vld && !dout_busy && rst) begin
        if (dout_xfers > 0 && last_dout == cyc - 1) back_to_back++;
        last_dout = cyc;
        dout_xfers++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_bench();
    m_acc = 0; m_cnt = 0; m_grp = 0; m_first_sum = -1;
    corrupt_grp = -1; withhold = 1'b0; busy_left = 0;
    res_q.delete();
    exp_q.delete();
    vld_seen = 0; din_xfers = 0; first_din = 0; last_din = 0;
    dout_xfers = 0; last_dout = 0; back_to_back = 0; pend_prev = 1'b0;
  endtask

  int t_start;

  task automatic start_run(input logic [15:0] ng, input logic [7:0] sd, input logic [7:0] bp);
    logic [7:0] v;
    if (done) begin
      tick(); start = 1'b1;
      tick(); start = 1'b0;
    end
    v = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < int'(ng) * GROUP; i++) begin
      exp_q.push_back(v);
      v = lfsr_next(v);
    end
    tick();
    start = 1'b1; num_groups = ng; seed = sd; busy_pat = bp;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_reached", done, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    clear_bench();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_din_vld", din_vld, 1'b0);
    check("rst_din_data", din_data, 8'h00);
    check("rst_dout_busy", dout_busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);

    // zero groups: straight to DONE
    start_run(16'd0, 8'h01, 8'h00);
    @(negedge clk);
    check("ng0_done", done, 1'b1);
    check("ng0_pass", pass, 1'b1);
    check("ng0_err", err_cnt, 16'd0);
    check("ng0_state", fsm_state, ST_DONE);
    check("ng0_no_vld", vld_seen, 0);
    check("ng0_dout_busy", dout_busy, 1'b1);

    // one group, no backpressure; 01,B8,5C,2E,17,B3,E1,C8 sums to 950
    tick(); clear_bench();
    start_run(16'd1, 8'h01, 8'h00);
    check("g1_vld_latency", din_vld, 1'b1);
    wait_done(200);
    check("g1_pass", pass, 1'b1);
    check("g1_err", err_cnt, 16'd0);
    check("g1_din_xfers", din_xfers, 8);
    check("g1_consecutive", last_din - first_din, 7);
    check("g1_sum", m_first_sum, 950);
    check("g1_dout_xfers", dout_xfers, 1);
    check("g1_exp_left", exp_q.size(), 0);

    // din backpressure at start, alternate-cycle dout acceptance
    tick(); clear_bench();
    busy_left = 7;
    start_run(16'd6, 8'h5A, 8'hAA);
    wait_done(600);
    check("g6_pass", pass, 1'b1);
    check("g6_err", err_cnt, 16'd0);
    check("g6_din_xfers", din_xfers, 48);
    check("g6_dout_xfers", dout_xfers, 6);
    check("g6_alternate", back_to_back, 0);
    check("g6_exp_left", exp_q.size(), 0);

    // seed 0 substituted by 01; group 2 corrupted by the far side
    tick(); clear_bench();
    corrupt_grp = 2;
    start_run(16'd5, 8'h00, 8'h00);
    wait_done(600);
    check("bad_err", err_cnt, 16'd1);
    check("bad_pass", pass, 1'b0);
    check("bad_timeout", timeout, 1'b0);
    check("bad_dout_xfers", dout_xfers, 5);
    check("bad_exp_left", exp_q.size(), 0);

    // outputs withheld: SEND stalls after EXP_DEPTH groups, then resumes
    tick(); clear_bench();
    withhold = 1'b1;
    start_run(16'd8, 8'h33, 8'h00);
    repeat (150) @(negedge clk);
    check("stall_din_xfers", din_xfers, 32);
    check("stall_din_vld", din_vld, 1'b0);
    check("stall_state", fsm_state, ST_SEND);
    tick(); withhold = 1'b0;
    wait_done(800);
    check("resume_pass", pass, 1'b1);
    check("resume_err", err_cnt, 16'd0);
    check("resume_din_xfers", din_xfers, 64);
    check("resume_dout_xfers", dout_xfers, 8);

    // outputs withheld for good: DRAIN times out
    tick(); clear_bench();
    withhold = 1'b1;
    start_run(16'd2, 8'h77, 8'h00);
    wait_done(3000);
    check("to_timeout", timeout, 1'b1);
    check("to_pass", pass, 1'b0);
    check("to_err", err_cnt, 16'd0);
    check("to_min_cycles", (cyc - t_start) >= 1024, 1'b1);
    check("to_dout_busy", dout_busy, 1'b1);

    // reset mid-SEND, then an identical fresh run
    tick(); clear_bench();
    start_run(16'd3, 8'h01, 8'h00);
    repeat (5) tick();
    @(negedge clk);
    check("pre_rst_vld", din_vld, 1'b1);
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mid_rst_din_vld", din_vld, 1'b0);
    check("mid_rst_dout_busy", dout_busy, 1'b1);
    check("mid_rst_err", err_cnt, 16'd0);
    check("mid_rst_state", fsm_state, ST_IDLE);
    check("mid_rst_done", done, 1'b0);
    tick(); clear_bench();
    start_run(16'd3, 8'h01, 8'h00);
    wait_done(400);
    check("rerun_pass", pass, 1'b1);
    check("rerun_din_xfers", din_xfers, 24);
    check("rerun_dout_xfers", dout_xfers, 3);
    check("rerun_sum", m_first_sum, 950);
    check("rerun_exp_left", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
